// File: rtl/craft_serial_state_reg.sv
// -----------------------------------------------------------------------------
// craft_serial_state_reg
//
// Nibble-serial state register for the CRAFT datapath. It holds N cells of W
// bits. The register supports four operations: parallel plaintext load, serial
// shift-in, in-place cell permutation, and rotate-with-XOR for serial key or
// tweak addition. A modulo-N cell counter tracks serial passes. It emits a
// one-cycle done pulse each time a pass completes.
//
// Cell i occupies state[W*(N-i)-1 -: W]. Cell 0 is the most significant cell
// and is the head.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset; takes priority over ce
//   ce         clock enable; when low, state and cnt hold and done clears
//   mode       00 SHIFT, 01 LOAD, 10 PERMUTE, 11 ROTXOR
//   plaintext  parallel load data (N*W bits)
//   in         serial cell input (W bits)
//   out        head cell (cell 0), driven straight from the register
//   state      full state register (N*W bits)
//   cnt        serial step counter, modulo N
//   done       registered pulse, high for one cycle after a full serial pass
// -----------------------------------------------------------------------------
module craft_serial_state_reg #(
   parameter int                W    = 4,
   parameter int                N    = 16,
   parameter int                IW   = $clog2(N),
   parameter logic [N*IW-1:0]   PERM = 64'hFCDEA98B65471230
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            ce,
   input  logic [1:0]      mode,
   input  logic [N*W-1:0]  plaintext,
   input  logic [W-1:0]    in,
   output logic [W-1:0]    out,
   output logic [N*W-1:0]  state,
   output logic [IW-1:0]   cnt,
   output logic            done
);

   typedef enum logic [1:0] {
      OP_SHIFT   = 2'b00,
      OP_LOAD    = 2'b01,
      OP_PERMUTE = 2'b10,
      OP_ROTXOR  = 2'b11
   } op_e;

   op_e            op;
   logic [W-1:0]   cell_q [N];
   logic [W-1:0]   cell_d [N];
   logic [IW-1:0]  cnt_q;
   logic [IW-1:0]  cnt_d;
   logic           done_q;
   logic           done_d;

   assign op = op_e'(mode);

   // Next-state values for an enabled edge. The register process decides
   // whether reset or ce applies.
   always_comb begin
      // NOTE: every variable gets a default before the case. This ensures
      // that no path leaves one unassigned, so no latch is inferred.
      cell_d = cell_q;
      cnt_d  = cnt_q;
      done_d = 1'b0;

      unique case (op)
         OP_SHIFT, OP_ROTXOR: begin
            for (int i = 0; i < N - 1; i++) begin
               cell_d[i] = cell_q[i+1];
            end
            // ROTXOR recirculates the departing head cell, mixed with in.
            cell_d[N-1] = (op == OP_ROTXOR) ? (cell_q[0] ^ in) : in;
            // The wrap is explicit at N-1. This keeps non-power-of-two N
            // correct, where IW bits would otherwise count past N-1.
            if (cnt_q == IW'(N - 1)) begin
               cnt_d  = '0;
               done_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         OP_LOAD: begin
            for (int i = 0; i < N; i++) begin
               cell_d[i] = plaintext[W*(N-i)-1 -: W];
            end
            cnt_d = '0;
         end
         OP_PERMUTE: begin
            // Every new cell reads the old cell array, so the permutation
            // happens all at once with no ordering hazards.
            for (int i = 0; i < N; i++) begin
               cell_d[i] = cell_q[PERM[IW*(N-i)-1 -: IW]];
            end
            cnt_d = '0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only. This
      // ensures that every register samples the pre-edge values.
      if (!rst_n) begin
         // NOTE: the cells are clearly reset, unlike a RAM. The whole
         // array is architecturally visible on state and must read 0.
         for (int i = 0; i < N; i++) begin
            cell_q[i] <= '0;
         end
         cnt_q  <= '0;
         done_q <= 1'b0;
      end else if (ce) begin
         cell_q <= cell_d;
         cnt_q  <= cnt_d;
         done_q <= done_d;
      end else begin
         // A stalled cycle never completes a pass, so the pulse drops.
         done_q <= 1'b0;
      end
   end

   always_comb begin
      state = '0;
      for (int i = 0; i < N; i++) begin
         state[W*(N-i)-1 -: W] = cell_q[i];
      end
   end

   assign out  = cell_q[0];
   assign cnt  = cnt_q;
   assign done = done_q;

endmodule

// File: tb/tb_craft_serial_state_reg.sv
// -----------------------------------------------------------------------------
// tb_craft_serial_state_reg
//
// Self-checking bench for craft_serial_state_reg. It uses three instances:
//   d0: default CRAFT geometry (W=4, N=16, CRAFT PermuteNibbles)
//   d1: W=8, N=8, identity permutation
//   d2: W=4, N=6, a non-power-of-two ring with a scrambled permutation
// A reference model keeps each register as a queue of cell values. It
// performs serial operations as pop/push on that queue and counts completed
// steps modulo N.
// -----------------------------------------------------------------------------
module tb_craft_serial_state_reg;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rn  [3];
   logic        ce  [3];
   logic [1:0]  md  [3];
   logic [63:0] pt  [3];
   logic [7:0]  din [3];

   logic [3:0]  out0;  logic [63:0] state0;  logic [3:0] cnt0;  logic done0;
   logic [7:0]  out1;  logic [63:0] state1;  logic [2:0] cnt1;  logic done1;
   logic [3:0]  out2;  logic [23:0] state2;  logic [2:0] cnt2;  logic done2;

   craft_serial_state_reg dut0 (
      .clk(clk), .rst_n(rn[0]), .ce(ce[0]), .mode(md[0]), .plaintext(pt[0]),
      .in(din[0][3:0]), .out(out0), .state(state0), .cnt(cnt0), .done(done0));

   craft_serial_state_reg #(
      .W(8), .N(8), .IW(3),
      .PERM({3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7})
   ) dut1 (
      .clk(clk), .rst_n(rn[1]), .ce(ce[1]), .mode(md[1]), .plaintext(pt[1]),
      .in(din[1]), .out(out1), .state(state1), .cnt(cnt1), .done(done1));

   craft_serial_state_reg #(
      .W(4), .N(6), .IW(3),
      .PERM({3'd5, 3'd0, 3'd4, 3'd1, 3'd3, 3'd2})
   ) dut2 (
      .clk(clk), .rst_n(rn[2]), .ce(ce[2]), .mode(md[2]), .plaintext(pt[2][23:0]),
      .in(din[2][3:0]), .out(out2), .state(state2), .cnt(cnt2), .done(done2));

   int checks   = 0;
   int failures = 0;

   // Reference model, one register per instance.
   int mq    [3][$];
   int mcnt  [3];
   bit mdone [3];
   int mn    [3];
   int mw    [3];
   int mperm [3][16];

   logic [63:0] a_state, a_out, a_cnt, a_done;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic model_edge(input int d, input bit r, input bit c, input logic [1:0] m,
                             input logic [63:0] p, input logic [7:0] i);
      int q[$];
      int tmp[$];
      int mask;
      int h;
      int v;
      mask = (1 << mw[d]) - 1;
      v    = int'(i) & mask;
      q    = mq[d];
      if (!r) begin
         q.delete();
         for (int k = 0; k < mn[d]; k++) q.push_back(0);
         mcnt[d]  = 0;
         mdone[d] = 1'b0;
      end else if (!c) begin
         mdone[d] = 1'b0;
      end else begin
         mdone[d] = 1'b0;
         case (m)
            2'd0, 2'd3: begin
               h = q.pop_front();
               q.push_back((m == 2'd3) ? (h ^ v) : v);
               mcnt[d] = mcnt[d] + 1;
               if (mcnt[d] == mn[d]) begin
                  mcnt[d]  = 0;
                  mdone[d] = 1'b1;
               end
            end
            2'd1: begin
               q.delete();
               for (int k = 0; k < mn[d]; k++)
                  q.push_back(int'(p >> (mw[d] * (mn[d] - 1 - k))) & mask);
               mcnt[d] = 0;
            end
            default: begin
               tmp = q;
               for (int k = 0; k < mn[d]; k++) q[k] = tmp[mperm[d][k]];
               mcnt[d] = 0;
            end
         endcase
      end
      mq[d] = q;
   endtask

   function automatic logic [63:0] mstate(input int d);
      logic [63:0] s;
      s = '0;
      for (int k = 0; k < mn[d]; k++) s = (s << mw[d]) | 64'(mq[d][k]);
      return s;
   endfunction

   task automatic sample(input int d);
      case (d)
         0:       begin a_state = state0;      a_out = 64'(out0); a_cnt = 64'(cnt0); a_done = 64'(done0); end
         1:       begin a_state = state1;      a_out = 64'(out1); a_cnt = 64'(cnt1); a_done = 64'(done1); end
         default: begin a_state = 64'(state2); a_out = 64'(out2); a_cnt = 64'(cnt2); a_done = 64'(done2); end
      endcase
   endtask

   // One clock edge on instance d. Each output is compared against the model
   // just after the edge. Afterwards the instance is parked with ce low.
   task automatic step(input int d, input bit r, input bit c, input logic [1:0] m,
                       input logic [63:0] p, input logic [7:0] i);
      rn[d] = r; ce[d] = c; md[d] = m; pt[d] = p; din[d] = i;
      @(posedge clk);
      model_edge(d, r, c, m, p, i);
      #1;
      sample(d);
      chk($sformatf("d%0d state", d), a_state, mstate(d));
      chk($sformatf("d%0d out", d),   a_out,   64'(mq[d][0]));
      chk($sformatf("d%0d cnt", d),   a_cnt,   64'(mcnt[d]));
      chk($sformatf("d%0d done", d),  a_done,  64'(mdone[d]));
      rn[d] = 1'b1; ce[d] = 1'b0;
   endtask

   typedef struct {
      logic [1:0]  mode;
      logic [63:0] pt;
      logic [7:0]  din;
      logic [63:0] exp_state;
      logic [3:0]  exp_out;
      int          exp_cnt;
      bit          exp_done;
   } vec_t;

   localparam logic [1:0] SH = 2'b00, LD = 2'b01, PM = 2'b10, RX = 2'b11;
   localparam logic [63:0] PT0 = 64'h0123456789ABCDEF;

   initial begin
      vec_t vt[8];
      int   pulses;
      logic [63:0] snap;
      int   perm0[16] = '{15, 12, 13, 14, 10, 9, 8, 11, 6, 5, 4, 7, 1, 2, 3, 0};
      int   perm2[6]  = '{5, 0, 4, 1, 3, 2};

      mn = '{16, 8, 6};
      mw = '{4, 8, 4};
      for (int k = 0; k < 16; k++) begin
         mperm[0][k] = perm0[k];
         mperm[1][k] = k;
         mperm[2][k] = (k < 6) ? perm2[k] : 0;
      end

      vt[0] = '{LD, PT0, 8'h0, PT0,                   4'h0, 0, 1'b0};
      vt[1] = '{SH, 64'h0, 8'h4, 64'h123456789ABCDEF4, 4'h1, 1, 1'b0};
      vt[2] = '{SH, 64'h0, 8'h8, 64'h23456789ABCDEF48, 4'h2, 2, 1'b0};
      vt[3] = '{SH, 64'h0, 8'hC, 64'h3456789ABCDEF48C, 4'h3, 3, 1'b0};
      vt[4] = '{SH, 64'h0, 8'h0, 64'h456789ABCDEF48C0, 4'h4, 4, 1'b0};
      vt[5] = '{LD, PT0, 8'h0, PT0,                   4'h0, 0, 1'b0};
      vt[6] = '{PM, 64'h0, 8'h0, 64'hFCDEA98B65471230, 4'hF, 0, 1'b0};
      vt[7] = '{PM, 64'h0, 8'h0, PT0,                 4'h0, 0, 1'b0};

      for (int d = 0; d < 3; d++) begin
         rn[d] = 1'b0; ce[d] = 1'b0; md[d] = 2'b00; pt[d] = '0; din[d] = '0;
      end

      // Reset state of every instance. Mode and ce are nonzero to show that
      // reset takes priority over them.
      for (int d = 0; d < 3; d++) step(d, 1'b0, 1'b1, RX, '1, 8'hFF);

      // Table vectors on the CRAFT geometry: load, shift, permute.
      for (int k = 0; k < 8; k++) begin
         step(0, 1'b1, 1'b1, vt[k].mode, vt[k].pt, vt[k].din);
         chk($sformatf("vec%0d state", k), a_state, vt[k].exp_state);
         chk($sformatf("vec%0d out", k),   a_out,   64'(vt[k].exp_out));
         chk($sformatf("vec%0d cnt", k),   a_cnt,   64'(vt[k].exp_cnt));
         chk($sformatf("vec%0d done", k),  a_done,  64'(vt[k].exp_done));
      end

      // ROTXOR with in=0: the ring returns to its start after a full pass.
      step(0, 1'b1, 1'b1, LD, PT0, 8'h0);
      pulses = 0;
      for (int k = 1; k <= 16; k++) begin
         step(0, 1'b1, 1'b1, RX, '0, 8'h0);
         pulses += int'(a_done[0]);
         if (k == 16) chk("rot0 done_at_16", a_done, 64'd1);
      end
      chk("rot0 state", a_state, PT0);
      chk("rot0 pulses", 64'(pulses), 64'd1);
      step(0, 1'b1, 1'b0, SH, '0, 8'h0);
      chk("rot0 done_drops", a_done, 64'd0);

      // ROTXOR with in=1: every cell picks up a single XOR with 1.
      step(0, 1'b1, 1'b1, LD, PT0, 8'h0);
      for (int k = 0; k < 16; k++) step(0, 1'b1, 1'b1, RX, '0, 8'h1);
      chk("rot1 state", a_state, 64'h1032547698BADCFE);

      // ce dropped for 3 cycles mid-pass.
      step(0, 1'b1, 1'b1, LD, PT0, 8'h0);
      for (int k = 0; k < 5; k++) step(0, 1'b1, 1'b1, RX, '0, 8'h3);
      snap = a_state;
      for (int k = 0; k < 3; k++) begin
         step(0, 1'b1, 1'b0, RX, '0, 8'h5);
         chk("stall state", a_state, snap);
         chk("stall cnt", a_cnt, 64'd5);
      end
      pulses = 0;
      for (int k = 1; k <= 11; k++) begin
         step(0, 1'b1, 1'b1, RX, '0, 8'h3);
         pulses += int'(a_done[0]);
         if (k == 11) chk("stall done_at_end", a_done, 64'd1);
      end
      chk("stall pulses", 64'(pulses), 64'd1);

      // Reset at cnt=15 abandons the pass.
      step(0, 1'b1, 1'b1, LD, PT0, 8'h0);
      for (int k = 0; k < 15; k++) step(0, 1'b1, 1'b1, SH, '0, 8'h9);
      chk("midrst cnt_before", a_cnt, 64'd15);
      step(0, 1'b0, 1'b1, SH, '0, 8'h9);
      chk("midrst state", a_state, 64'd0);
      chk("midrst out", a_out, 64'd0);
      chk("midrst cnt", a_cnt, 64'd0);
      chk("midrst done", a_done, 64'd0);
      step(0, 1'b1, 1'b1, SH, '0, 8'h9);
      chk("midrst no_done", a_done, 64'd0);

      // W=8, N=8 identity instance: a full pass of 0xAA.
      step(1, 1'b1, 1'b1, LD, 64'h0011223344556677, 8'h0);
      pulses = 0;
      for (int k = 1; k <= 8; k++) begin
         step(1, 1'b1, 1'b1, SH, '0, 8'hAA);
         pulses += int'(a_done[0]);
         if (k == 8) chk("w8 done_at_8", a_done, 64'd1);
      end
      chk("w8 state", a_state, 64'hAAAAAAAAAAAAAAAA);
      chk("w8 pulses", 64'(pulses), 64'd1);
      // 7 shifts then LOAD: no pass completes.
      pulses = 0;
      for (int k = 0; k < 7; k++) begin
         step(1, 1'b1, 1'b1, SH, '0, 8'h5C);
         pulses += int'(a_done[0]);
      end
      step(1, 1'b1, 1'b1, LD, 64'h8877665544332211, 8'h0);
      pulses += int'(a_done[0]);
      chk("w8 partial pulses", 64'(pulses), 64'd0);
      chk("w8 partial cnt", a_cnt, 64'd0);

      // N=6 instance: the wrap occurs at 5, not at 7.
      step(2, 1'b1, 1'b1, LD, 64'hABCDEF, 8'h0);
      for (int k = 1; k <= 6; k++) begin
         step(2, 1'b1, 1'b1, SH, '0, 8'h1);
         if (k == 5) chk("n6 cnt_at_5", a_cnt, 64'd5);
         if (k == 6) chk("n6 wrap_done", a_done, 64'd1);
      end
      chk("n6 state", a_state, 64'h111111);
      chk("n6 cnt_wrapped", a_cnt, 64'd0);

      // Randomised traffic against the model, biased toward serial steps.
      for (int pass = 0; pass < 2; pass++) begin
         int d;
         d = (pass == 0) ? 0 : 2;
         for (int k = 0; k < 400; k++) begin
            bit         r;
            bit         c;
            logic [1:0] m;
            r = ($urandom_range(0, 31) != 0);
            c = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) < 6) m = ($urandom_range(0, 1) == 0) ? SH : RX;
            else                          m = ($urandom_range(0, 1) == 0) ? LD : PM;
            step(d, r, c, m, {$urandom, $urandom}, 8'($urandom));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
